// File: rtl/hv_serializer_pkg.sv
// hv_serializer_pkg: shared constants, occupancy states and slot record for the hypervector serializer.
package hv_pkg;
  localparam int DEF_DIM = 1023;
  localparam int DEF_WORD = 32;
  localparam int DEF_NW = (DEF_DIM + 1) / DEF_WORD;
  localparam int DEF_NW_W = $clog2(DEF_NW);
  typedef enum logic [1:0] {EMPTY, ONE, FULL} occ_t;
  typedef struct packed {
    logic [DEF_DIM:0] data;
    logic             lastf;
  } slot_t;
  function automatic int idx_bits(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/hv_serializer_if.sv
// hv_serializer_if: core store handshake plus AXI-Stream master signals of the serializer.
interface hv_serializer_if import hv_pkg::*; #(
  parameter int DIM = DEF_DIM,
  parameter int WORD = DEF_WORD
);
  logic            store;
  logic [DIM:0]    core_result;
  logic            last;
  logic            store_ready;
  logic            drop;
  logic            dst_ready;
  logic            dst_valid;
  logic [WORD-1:0] dst_data;
  logic            dst_last;
  modport slave (
    input  store, core_result, last, dst_ready,
    output store_ready, drop, dst_valid, dst_data, dst_last
  );
  modport master (
    output store, core_result, last, dst_ready,
    input  store_ready, drop, dst_valid, dst_data, dst_last
  );
endinterface

// File: rtl/hv_serializer_word_mux.sv
// hv_word_mux: NW:1 beat select; HV_SERIALIZER_MSW_FIRST_EN reverses the order to most significant word first.
module hv_word_mux import hv_pkg::*; #(
  parameter int DIM = DEF_DIM,
  parameter int WORD = DEF_WORD,
  parameter int NW = (DIM + 1) / WORD,
  parameter int IW = idx_bits(NW)
) (
  input  logic [DIM:0]    vec,
  input  logic [IW-1:0]   idx,
  output logic [WORD-1:0] word
);
  logic [IW-1:0] sel;
  always_comb begin
`ifdef HV_SERIALIZER_MSW_FIRST_EN
    sel = IW'(NW - 1) - idx;
`else
    sel = idx;
`endif
    word = vec[int'(sel) * WORD +: WORD];
  end
endmodule

// File: rtl/hv_serializer.sv
// hv_serializer: two-slot ping-pong capture of core hypervectors, streamed out as WORD-bit AXIS beats.
// Build option: HV_SERIALIZER_MSW_FIRST_EN emits most significant word first.
module hv_serializer import hv_pkg::*; #(
  parameter int DIM = DEF_DIM,
  parameter int WORD = DEF_WORD
) (
  input logic clk,
  input logic rst,
  hv_serializer_if.slave bus
);
  localparam int NW = (DIM + 1) / WORD;
  localparam int IW = idx_bits(NW);
  typedef struct packed {
    logic [DIM:0] data;
    logic         lastf;
  } rec_t;
  if ((DIM + 1) % WORD != 0 || NW < 2) begin : g_bad_cfg
    $error("hv_serializer: DIM+1 must be a multiple of WORD with at least two words");
  end
  occ_t          occ, occ_nx;
  rec_t          slot [2];
  logic          wp, rp, drop_r, acc, beat, fin;
  logic [IW-1:0] widx;
  // rp always names the oldest vector, so occupancy alone decides dst_valid
  always_comb begin
    acc = bus.store & (occ != FULL);
    beat = (occ != EMPTY) & bus.dst_ready;
    fin = beat & (widx == IW'(NW - 1));
    occ_nx = (acc & !fin) ? (occ == EMPTY ? ONE : FULL) :
             (fin & !acc) ? (occ == FULL ? ONE : EMPTY) : occ;
  end
  always_ff @(posedge clk) begin
    if (rst) occ <= EMPTY;
    else occ <= occ_nx;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      slot[0] <= '0;
      slot[1] <= '0;
      wp <= 1'b0;
      rp <= 1'b0;
      widx <= '0;
      drop_r <= 1'b0;
    end else begin
      if (acc) begin
        slot[wp] <= rec_t'{data: bus.core_result, lastf: bus.last};
        wp <= ~wp;
      end
      if (bus.store & !acc) drop_r <= 1'b1;
      if (beat) widx <= fin ? '0 : widx + 1'b1;
      if (fin) rp <= ~rp;
    end
  end
  assign bus.store_ready = occ != FULL;
  assign bus.drop = drop_r;
  assign bus.dst_valid = occ != EMPTY;
  assign bus.dst_last = bus.dst_valid & slot[rp].lastf & (widx == IW'(NW - 1));
  hv_word_mux #(.DIM(DIM), .WORD(WORD), .NW(NW), .IW(IW)) u_mux (
    .vec(slot[rp].data),
    .idx(widx),
    .word(bus.dst_data)
  );
endmodule

// File: tb/tb_hv_serializer.sv
// tb_hv_serializer: directed and random stimulus at DIM=63/WORD=32 against a queue-based stream model.
module tb_hv_serializer;
  localparam int NW = 2;
`ifdef HV_SERIALIZER_MSW_FIRST_EN
  localparam logic [31:0] W0 = 32'hDEADBEEF, W1 = 32'h01234567;
`else
  localparam logic [31:0] W0 = 32'h01234567, W1 = 32'hDEADBEEF;
`endif
  localparam logic [63:0] VA = 64'h1111_2222_3333_4444, VB = 64'h5555_6666_7777_8888;
  localparam logic [63:0] VC = 64'h9999_AAAA_BBBB_CCCC, VD = 64'hCAFE_F00D_1234_ABCD;
  logic clk = 0, rst = 1, started = 0;
  int total = 0, bad = 0;
  hv_serializer_if #(.DIM(63), .WORD(32)) bus ();
  hv_serializer #(.DIM(63), .WORD(32)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  function automatic logic [31:0] wsel(input logic [63:0] v, input int k);
`ifdef HV_SERIALIZER_MSW_FIRST_EN
    k = NW - 1 - k;
`endif
    return v[k*32 +: 32];
  endfunction
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h t=%0t", nm, act, exp, $time);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic put(input logic s, input logic [63:0] v, input logic l);
    bus.store = s;
    bus.core_result = v;
    bus.last = l;
  endtask
  logic [64:0] q[$];
  int bidx = 0;
  logic mdrop = 0, ev, macc;
  always @(negedge clk) if (started) begin
    ev = q.size() > 0;
    chk("m_valid", bus.dst_valid, ev);
    chk("m_store_ready", bus.store_ready, q.size() < 2);
    chk("m_drop", bus.drop, mdrop);
    if (ev) begin
      chk("m_data", bus.dst_data, wsel(q[0][64:1], bidx));
      chk("m_last", bus.dst_last, q[0][0] && bidx == NW - 1);
    end else chk("m_last_idle", bus.dst_last, 0);
    if (rst) begin
      q.delete();
      bidx = 0;
      mdrop = 0;
    end else begin
      macc = bus.store && q.size() < 2;
      if (bus.store && !macc) mdrop = 1;
      if (ev && bus.dst_ready) begin
        bidx++;
        if (bidx == NW) begin
          void'(q.pop_front());
          bidx = 0;
        end
      end
      if (macc) q.push_back({bus.core_result, bus.last});
    end
  end
  initial begin
    put(0, '0, 0);
    bus.dst_ready = 0;
    tick();
    started = 1;
    tick();
    chk("rst_valid", bus.dst_valid, 0);
    chk("rst_last", bus.dst_last, 0);
    chk("rst_data", bus.dst_data, 0);
    chk("rst_store_ready", bus.store_ready, 1);
    chk("rst_drop", bus.drop, 0);
    rst = 0;
    // single vector, ready held high
    bus.dst_ready = 1;
    put(1, 64'hDEAD_BEEF_0123_4567, 1);
    chk("single_pre_valid", bus.dst_valid, 0);
    tick();
    put(0, '0, 0);
    chk("single_lat_valid", bus.dst_valid, 1);
    chk("single_b0", bus.dst_data, W0);
    chk("single_b0_last", bus.dst_last, 0);
    tick();
    chk("single_b1", bus.dst_data, W1);
    chk("single_b1_last", bus.dst_last, 1);
    tick();
    chk("single_done", bus.dst_valid, 0);
    // backpressure
    bus.dst_ready = 0;
    put(1, 64'hDEAD_BEEF_0123_4567, 1);
    tick();
    put(0, '0, 0);
    for (int i = 0; i < 5; i++) begin
      chk("bp_hold", bus.dst_data, W0);
      tick();
    end
    bus.dst_ready = 1;
    chk("bp_b0", bus.dst_data, W0);
    tick();
    chk("bp_b1", bus.dst_data, W1);
    chk("bp_b1_last", bus.dst_last, 1);
    tick();
    chk("bp_done", bus.dst_valid, 0);
    // ping-pong fill, refused third store
    bus.dst_ready = 0;
    put(1, VA, 0);
    tick();
    put(1, VB, 1);
    tick();
    chk("pp_full", bus.store_ready, 0);
    put(1, VC, 1);
    tick();
    put(0, '0, 0);
    chk("pp_drop", bus.drop, 1);
    bus.dst_ready = 1;
    chk("pp_a0", bus.dst_data, wsel(VA, 0));
    tick();
    chk("pp_a1", bus.dst_data, wsel(VA, 1));
    chk("pp_a1_last", bus.dst_last, 0);
    tick();
    chk("pp_b0", bus.dst_data, wsel(VB, 0));
    tick();
    chk("pp_b1", bus.dst_data, wsel(VB, 1));
    chk("pp_b1_last", bus.dst_last, 1);
    tick();
    chk("pp_no_c", bus.dst_valid, 0);
    // accept-while-free in FULL: refused
    rst = 1;
    tick();
    rst = 0;
    bus.dst_ready = 0;
    put(1, VA, 0);
    tick();
    put(1, VB, 1);
    tick();
    put(0, '0, 0);
    bus.dst_ready = 1;
    tick();
    put(1, VC, 1);
    tick();
    put(0, '0, 0);
    chk("full_free_drop", bus.drop, 1);
    chk("full_free_b0", bus.dst_data, wsel(VB, 0));
    tick();
    tick();
    chk("full_free_no_c", bus.dst_valid, 0);
    // accept-while-free in ONE: accepted, no bubble
    rst = 1;
    tick();
    rst = 0;
    put(1, VA, 0);
    tick();
    put(0, '0, 0);
    tick();
    put(1, VC, 1);
    chk("one_free_a1", bus.dst_data, wsel(VA, 1));
    tick();
    put(0, '0, 0);
    chk("one_free_c0_valid", bus.dst_valid, 1);
    chk("one_free_c0", bus.dst_data, wsel(VC, 0));
    chk("one_free_drop", bus.drop, 0);
    tick();
    chk("one_free_c1", bus.dst_data, wsel(VC, 1));
    chk("one_free_c1_last", bus.dst_last, 1);
    tick();
    // reset mid-vector with drop set and a buffered vector
    bus.dst_ready = 0;
    put(1, VA, 1);
    tick();
    put(1, VB, 1);
    tick();
    put(1, VC, 1);
    tick();
    put(0, '0, 0);
    bus.dst_ready = 1;
    tick();
    rst = 1;
    tick();
    rst = 0;
    chk("mid_rst_valid", bus.dst_valid, 0);
    chk("mid_rst_ready", bus.store_ready, 1);
    chk("mid_rst_drop", bus.drop, 0);
    put(1, VD, 1);
    tick();
    put(0, '0, 0);
    chk("mid_rst_d0", bus.dst_data, wsel(VD, 0));
    tick();
    chk("mid_rst_d1", bus.dst_data, wsel(VD, 1));
    tick();
    chk("mid_rst_done", bus.dst_valid, 0);
    // random traffic
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom % 150) == 0;
      put(($urandom % 3) == 0, {$urandom, $urandom}, $urandom % 2);
      bus.dst_ready = ($urandom % 4) != 0;
      tick();
    end
    put(0, '0, 0);
    rst = 0;
    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
